datapath_sequencer: RTL and testbench

- Multi-cycle control unit directly upstream of the Datapath.
- Fetches 32-bit instructions over a req/ack instruction-memory port, decodes them, and drives the Datapath control word (SA, SB, DA, FS, C0, M, K, WR, EN_ALU, EN_B, EN_ADDR_ALU, RCS, RWE, ROE) one state at a time.
- Samples the Datapath STAT flags for conditional branches.

---
 rtl/datapath_sequencer.sv | 215 +++++++++++++++++++++
 tb/tb_datapath_sequencer.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/datapath_sequencer.sv
// Multi-cycle fetch/decode/execute sequencer that drives the Datapath control word.
// Every output is a flop; the control word is loaded in DECODE and cleared when FETCH is re-entered.
module datapath_sequencer #(
    parameter int          PC_W     = 16,
    parameter int unsigned RESET_PC = 0,
    parameter int unsigned ZERO_REG = 31
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic            run,
    output logic            imem_req,
    output logic [PC_W-1:0] imem_addr,
    input  logic            imem_ack,
    input  logic [31:0]     imem_data,
    input  logic [3:0]      STAT,
    output logic [4:0]      SA,
    output logic [4:0]      SB,
    output logic [4:0]      DA,
    output logic [4:0]      FS,
    output logic            C0,
    output logic            M,
    output logic [63:0]     K,
    output logic            WR,
    output logic            EN_ALU,
    output logic            EN_B,
    output logic            EN_ADDR_ALU,
    output logic            RCS,
    output logic            RWE,
    output logic            ROE,
    output logic [PC_W-1:0] pc,
    output logic            halted,
    output logic [3:0]      flags
);

    localparam logic [5:0] OP_NOP  = 6'h00;
    localparam logic [5:0] OP_ADD  = 6'h01;
    localparam logic [5:0] OP_SUB  = 6'h02;
    localparam logic [5:0] OP_ADDI = 6'h03;
    localparam logic [5:0] OP_LDI  = 6'h04;
    localparam logic [5:0] OP_MOV  = 6'h05;
    localparam logic [5:0] OP_ST   = 6'h06;
    localparam logic [5:0] OP_LD   = 6'h07;
    localparam logic [5:0] OP_BZ   = 6'h08;
    localparam logic [5:0] OP_BNZ  = 6'h09;

    localparam logic [4:0] FS_ADD  = 5'b01000;
    localparam logic [4:0] FS_SUB  = 5'b01001;
    localparam logic [4:0] FS_PASS = 5'b00100;

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_HALT
    } state_t;

    typedef struct packed {
        logic [4:0]  sa;
        logic [4:0]  sb;
        logic [4:0]  da;
        logic [4:0]  fs;
        logic        c0;
        logic        m;
        logic [63:0] k;
        logic        wr;
        logic        en_alu;
        logic        en_b;
        logic        en_addr_alu;
        logic        rcs;
        logic        rwe;
        logic        roe;
    } ctl_t;

    state_t     state;
    logic [31:0] ir;
    ctl_t       ctl;
    ctl_t       dec;
    logic       is_exec;
    logic       is_skip;
    logic       br_taken;
    logic       upd_flags;
    logic [5:0] op;

    assign op = ir[31:26];

    always_comb begin
        dec     = '0;
        dec.da  = ir[25:21];
        dec.sa  = ir[20:16];
        is_exec = 1'b0;
        is_skip = 1'b0;
        case (op)
            OP_NOP: is_skip = 1'b1;
            OP_ADD, OP_SUB: begin
                is_exec    = 1'b1;
                dec.sb     = ir[15:11];
                dec.fs     = (op == OP_SUB) ? FS_SUB : FS_ADD;
                dec.c0     = (op == OP_SUB);
                dec.m      = 1'b1;
                dec.en_alu = 1'b1;
                dec.wr     = 1'b1;
            end
            OP_ADDI, OP_LDI: begin
                is_exec    = 1'b1;
                dec.fs     = FS_ADD;
                dec.k      = {{48{ir[15]}}, ir[15:0]};
                dec.en_alu = 1'b1;
                dec.wr     = 1'b1;
                if (op == OP_LDI) dec.sa = 5'(ZERO_REG);
            end
            OP_MOV: begin
                is_exec  = 1'b1;
                dec.sb   = ir[15:11];
                dec.en_b = 1'b1;
                dec.wr   = 1'b1;
            end
            OP_ST: begin
                is_exec         = 1'b1;
                dec.sb          = ir[15:11];
                dec.fs          = FS_PASS;
                dec.en_b        = 1'b1;
                dec.en_addr_alu = 1'b1;
                dec.rcs         = 1'b1;
                dec.rwe         = 1'b1;
            end
            OP_LD: begin
                is_exec         = 1'b1;
                dec.fs          = FS_PASS;
                dec.en_addr_alu = 1'b1;
                dec.rcs         = 1'b1;
                dec.roe         = 1'b1;
            end
            OP_BZ, OP_BNZ: is_skip = 1'b1;
            default: ;  // HALT and every unlisted opcode fall through to the halt path
        endcase
    end

    // Branches test the flags latched by the last ALU op, not the live STAT.
    assign br_taken  = ((op == OP_BZ) && flags[0]) || ((op == OP_BNZ) && !flags[0]);
    assign upd_flags = (op == OP_ADD) || (op == OP_SUB) || (op == OP_ADDI);

    always_ff @(posedge CLK) begin
        if (RST) begin
            state    <= S_IDLE;
            pc       <= PC_W'(RESET_PC);
            ir       <= '0;
            ctl      <= '0;
            flags    <= '0;
            halted   <= 1'b0;
            imem_req <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (run) begin
                        state    <= S_FETCH;
                        imem_req <= 1'b1;
                    end
                end
                S_FETCH: begin
                    if (imem_ack) begin
                        ir       <= imem_data;
                        pc       <= pc + PC_W'(1);
                        imem_req <= 1'b0;
                        state    <= S_DECODE;
                    end
                end
                S_DECODE: begin
                    if (is_exec) begin
                        ctl   <= dec;
                        state <= S_EXEC;
                    end else if (is_skip) begin
                        if (br_taken) pc <= pc + PC_W'($signed(ir[15:0]));
                        imem_req <= 1'b1;
                        state    <= S_FETCH;
                    end else begin
                        halted <= 1'b1;
                        state  <= S_HALT;
                    end
                end
                S_EXEC: begin
                    if (upd_flags) flags <= STAT;
                    if (op == OP_LD) begin
                        ctl.wr <= 1'b1;
                        state  <= S_MEM;
                    end else begin
                        ctl      <= '0;
                        imem_req <= 1'b1;
                        state    <= S_FETCH;
                    end
                end
                S_MEM: begin
                    ctl      <= '0;
                    imem_req <= 1'b1;
                    state    <= S_FETCH;
                end
                S_HALT: ;
                default: state <= S_IDLE;
            endcase
        end
    end

    assign imem_addr   = pc;
    assign SA          = ctl.sa;
    assign SB          = ctl.sb;
    assign DA          = ctl.da;
    assign FS          = ctl.fs;
    assign C0          = ctl.c0;
    assign M           = ctl.m;
    assign K           = ctl.k;
    assign WR          = ctl.wr;
    assign EN_ALU      = ctl.en_alu;
    assign EN_B        = ctl.en_b;
    assign EN_ADDR_ALU = ctl.en_addr_alu;
    assign RCS         = ctl.rcs;
    assign RWE         = ctl.rwe;
    assign ROE         = ctl.roe;

endmodule

// File: tb/tb_datapath_sequencer.sv
// Bench for datapath_sequencer: directed steps plus a random instruction stream,
// each checked cycle by cycle against an instruction-level model of pc, flags and control word.
module tb_datapath_sequencer;

    logic        CLK = 1'b0;
    logic        RST, run, imem_ack;
    logic [31:0] imem_data;
    logic [3:0]  STAT;
    logic        imem_req;
    logic [15:0] imem_addr, pc;
    logic [4:0]  SA, SB, DA, FS;
    logic        C0, M, WR, EN_ALU, EN_B, EN_ADDR_ALU, RCS, RWE, ROE, halted;
    logic [63:0] K;
    logic [3:0]  flags;

    always #5 CLK = ~CLK;

    datapath_sequencer dut (
        .CLK(CLK), .RST(RST), .run(run),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_data(imem_data),
        .STAT(STAT), .SA(SA), .SB(SB), .DA(DA), .FS(FS), .C0(C0), .M(M), .K(K), .WR(WR),
        .EN_ALU(EN_ALU), .EN_B(EN_B), .EN_ADDR_ALU(EN_ADDR_ALU), .RCS(RCS), .RWE(RWE), .ROE(ROE),
        .pc(pc), .halted(halted), .flags(flags)
    );

    typedef struct packed {
        logic [4:0]  sa, sb, da, fs;
        logic        c0, m;
        logic [63:0] k;
        logic        wr, en_alu, en_b, en_addr, rcs, rwe, roe;
    } cw_t;

    int          n_cmp  = 0;
    int          n_fail = 0;
    logic [15:0] mpc;
    logic [3:0]  mflags;

    function automatic cw_t dut_cw();
        return '{SA, SB, DA, FS, C0, M, K, WR, EN_ALU, EN_B, EN_ADDR_ALU, RCS, RWE, ROE};
    endfunction

    // Control word the instruction set prescribes for an executing instruction.
    function automatic cw_t exp_cw(input logic [31:0] ins, input bit mem_cycle);
        cw_t c = '0;
        logic [5:0] op = ins[31:26];
        c.da = ins[25:21];
        c.sa = ins[20:16];
        case (op)
            6'h01: begin c.sb = ins[15:11]; c.fs = 5'b01000; c.m = 1; c.en_alu = 1; c.wr = 1; end
            6'h02: begin c.sb = ins[15:11]; c.fs = 5'b01001; c.c0 = 1; c.m = 1; c.en_alu = 1; c.wr = 1; end
            6'h03, 6'h04: begin
                c.fs = 5'b01000; c.k = {{48{ins[15]}}, ins[15:0]}; c.en_alu = 1; c.wr = 1;
                if (op == 6'h04) c.sa = 5'd31;
            end
            6'h05: begin c.sb = ins[15:11]; c.en_b = 1; c.wr = 1; end
            6'h06: begin c.sb = ins[15:11]; c.fs = 5'b00100; c.en_b = 1; c.en_addr = 1; c.rcs = 1; c.rwe = 1; end
            6'h07: begin c.fs = 5'b00100; c.en_addr = 1; c.rcs = 1; c.roe = 1; c.wr = mem_cycle; end
            default: ;
        endcase
        return c;
    endfunction

    function automatic logic [31:0] mk(input logic [5:0] op, input logic [4:0] da, sa, sb);
        return {op, da, sa, sb, 11'h0};
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(negedge CLK);
    endtask

    task automatic do_reset(input bit go);
        RST = 1; run = 1; imem_ack = 1; STAT = 4'($urandom);
        cyc(); cyc();
        chk("reset_state", {imem_req, halted, flags, pc, dut_cw()}, '0);
        RST = 0; run = go; imem_ack = 0; mpc = '0; mflags = '0;
        if (!go) begin
            repeat (2) begin cyc(); chk("idle_no_req", imem_req, 0); end
            run = 1;
        end
        cyc();
        chk("req_after_reset", imem_req, 1);
    endtask

    // Handshake one instruction; returns at the negedge of the DECODE cycle.
    task automatic fetch(input logic [31:0] ins, input int waits);
        chk("fetch_addr", {imem_req, imem_addr}, {1'b1, mpc});
        repeat (waits) begin
            imem_ack = 0; imem_data = $urandom;
            cyc();
            chk("fetch_hold", {imem_req, imem_addr}, {1'b1, mpc});
        end
        imem_ack = 1; imem_data = ins;
        cyc();
        imem_ack = 1'($urandom); imem_data = $urandom;
        mpc = mpc + 16'd1;
        chk("pc_inc", pc, mpc);
        chk("decode_idle", {imem_req, dut_cw()}, '0);
    endtask

    task automatic step(input logic [31:0] ins, input int waits, input logic [3:0] stat);
        logic [5:0] op = ins[31:26];
        fetch(ins, waits);
        STAT = 4'($urandom);
        cyc();
        if (op == 6'h00 || op == 6'h08 || op == 6'h09) begin
            if ((op == 6'h08 && mflags[0]) || (op == 6'h09 && !mflags[0])) mpc = mpc + ins[15:0];
            chk("skip_to_fetch", {imem_req, dut_cw()}, {1'b1, cw_t'(0)});
        end else if (op >= 6'h01 && op <= 6'h07) begin
            chk("exec_cw", dut_cw(), exp_cw(ins, 0));
            STAT = stat; imem_ack = 1'($urandom);
            cyc();
            if (op == 6'h07) begin
                chk("mem_cw", dut_cw(), exp_cw(ins, 1));
                STAT = 4'($urandom); imem_ack = 1'($urandom);
                cyc();
            end
            if (op >= 6'h01 && op <= 6'h03) mflags = stat;
            chk("back_to_fetch", {imem_req, dut_cw()}, {1'b1, cw_t'(0)});
            chk("flags", flags, mflags);
        end else begin
            chk("halt_entry", {halted, imem_req, dut_cw()}, {2'b10, cw_t'(0)});
        end
    endtask

    task automatic halt_test(input logic [31:0] ins);
        step(ins, 1, 4'h0);
        for (int i = 0; i < 10; i++) begin
            imem_ack = 1; imem_data = $urandom;
            cyc();
            chk("halt_stays", {halted, imem_req}, 2'b10);
        end
        do_reset(1);
        chk("halt_reset_pc", imem_addr, 16'h0000);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [5:0] ops [10] = '{6'h00, 6'h01, 6'h02, 6'h03, 6'h04, 6'h05, 6'h06, 6'h07, 6'h08, 6'h09};
        logic [31:0] ld;
        imem_data = '0;
        cyc();
        do_reset(1);

        // Directed program
        step(32'h0C3E0005, 3, 4'b0110);          // ADDI r1,r30,#5
        step(32'h04013800, 0, 4'b1000);          // ADD r0,r1,r7
        step(32'h08200000, 1, 4'b0001);          // SUB r1,r0,r0 -> Z
        step(32'h00000000, 0, 4'b1111);          // NOP, pc -> 4
        step(32'h2000FFFE, 2, 4'b0000);          // BZ -2 taken -> 3
        step(32'h08200000, 0, 4'b0000);          // SUB clears Z
        step(32'h2000FFFE, 0, 4'b0000);          // BZ not taken -> 5
        step(mk(6'h06, 5'd9, 5'd2, 5'd5), 1, 4'b1010);   // ST
        step(mk(6'h07, 5'd4, 5'd2, 5'd0), 0, 4'b0101);   // LD
        step({6'h04, 5'd3, 5'd7, 16'h8001}, 0, 4'b0011); // LDI negative imm
        step(mk(6'h05, 5'd6, 5'd1, 5'd12), 0, 4'b1110);  // MOV

        // Random stream
        for (int i = 0; i < 80; i++) begin
            step({ops[$urandom_range(0, 9)], 26'($urandom)}, $urandom_range(0, 3), 4'($urandom));
        end

        halt_test(32'hFC000000);
        halt_test(32'h80000000);

        // pc wrap: BNZ (flags clear after reset) to 0xFFFF, then fetch there
        step({6'h09, 10'h0, 16'hFFFE}, 0, 4'h0);
        chk("wrap_target", imem_addr, 16'hFFFF);
        step(32'h00000000, 1, 4'h0);
        chk("wrap_pc", pc, 16'h0000);

        // Reset during the MEM cycle of LD
        ld = mk(6'h07, 5'd17, 5'd8, 5'd0);
        fetch(ld, 0);
        cyc();
        chk("ld_exec", dut_cw(), exp_cw(ld, 0));
        cyc();
        chk("ld_mem", dut_cw(), exp_cw(ld, 1));
        RST = 1; run = 0;
        cyc();
        chk("ld_reset_wr", {WR, imem_req, pc}, '0);
        do_reset(0);
        step(32'h0C3E0005, 0, 4'b0100);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
